// File: rtl/router_sync_n.sv
// Synchroniser between the router FSM and NUM_PORTS output FIFOs: latches the
// destination address, steers write enables, muxes full flags and runs per-channel read watchdogs.
module router_sync_n #(
  parameter int NUM_PORTS = 3,
  parameter int ADDR_W    = 2,
  parameter int TIMEOUT   = 30,
  parameter int CNT_W     = 10
) (
  input  logic                 clk,
  input  logic                 resetn,
  input  logic                 detect_add,
  input  logic                 we_reg,
  input  logic [ADDR_W-1:0]    datain,
  input  logic [NUM_PORTS-1:0] re,
  input  logic [NUM_PORTS-1:0] empty,
  input  logic [NUM_PORTS-1:0] full,
  output logic [NUM_PORTS-1:0] we,
  output logic                 fifo_full,
  output logic [NUM_PORTS-1:0] v_out,
  output logic [NUM_PORTS-1:0] soft_rst,
  output logic                 addr_err,
  output logic [ADDR_W-1:0]    sel_addr
);

  // One extra bit so NUM_PORTS == 2**ADDR_W is still representable.
  localparam logic [ADDR_W:0]  PORTS_LIM = (ADDR_W+1)'(NUM_PORTS);
  localparam logic [CNT_W-1:0] CNT_LAST  = CNT_W'(TIMEOUT - 1);

  logic [ADDR_W-1:0]    sel_addr_q, sel_addr_d;
  logic                 addr_err_q, addr_err_d;
  logic [NUM_PORTS-1:0] port_hit;

  always_comb begin
    sel_addr_d = sel_addr_q;
    addr_err_d = addr_err_q;
    if (detect_add) begin
      sel_addr_d = datain;
      addr_err_d = ({1'b0, datain} >= PORTS_LIM);
    end
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      sel_addr_q <= '0;
      addr_err_q <= 1'b0;
    end else begin
      sel_addr_q <= sel_addr_d;
      addr_err_q <= addr_err_d;
    end
  end

  for (genvar g = 0; g < NUM_PORTS; g++) begin : gen_dec
    assign port_hit[g] = (sel_addr_q == ADDR_W'(g));
  end

  // Steering always uses the registered address, so a header arriving with a
  // write strobe still targets the previous packet's FIFO.
  assign we        = (we_reg && !addr_err_q) ? port_hit : '0;
  assign fifo_full = !addr_err_q && (|(full & port_hit));
  assign v_out     = ~empty;
  assign addr_err  = addr_err_q;
  assign sel_addr  = sel_addr_q;

  for (genvar g = 0; g < NUM_PORTS; g++) begin : gen_wd
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             pulse_q, pulse_d;
    logic             stall;

    assign stall = ~empty[g] & ~re[g];

    // A read or an empty FIFO restarts the count, even on the terminal edge.
    always_comb begin
      cnt_d   = '0;
      pulse_d = 1'b0;
      if (stall) begin
        if (cnt_q == CNT_LAST) begin
          pulse_d = 1'b1;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
    end

    always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
        cnt_q   <= '0;
        pulse_q <= 1'b0;
      end else begin
        cnt_q   <= cnt_d;
        pulse_q <= pulse_d;
      end
    end

    assign soft_rst[g] = pulse_q;
  end

endmodule

// File: tb/tb_router_sync_n.sv
// Directed bench for router_sync_n: default 3-port instance plus an 8-port
// instance with a short timeout.
module tb_router_sync_n;

  logic       clk;
  logic       resetn, detect_add, we_reg;
  logic [1:0] datain;
  logic [2:0] re, empty, full;
  logic [2:0] we, v_out, soft_rst;
  logic       fifo_full, addr_err;
  logic [1:0] sel_addr;

  logic       b_resetn, b_detect_add, b_we_reg;
  logic [2:0] b_datain;
  logic [7:0] b_re, b_empty, b_full;
  logic [7:0] b_we, b_v_out, b_soft_rst;
  logic       b_fifo_full, b_addr_err;
  logic [2:0] b_sel_addr;

  int n_cmp;
  int n_fail;

  router_sync_n dut (
    .clk(clk), .resetn(resetn), .detect_add(detect_add), .we_reg(we_reg),
    .datain(datain), .re(re), .empty(empty), .full(full),
    .we(we), .fifo_full(fifo_full), .v_out(v_out), .soft_rst(soft_rst),
    .addr_err(addr_err), .sel_addr(sel_addr)
  );

  router_sync_n #(.NUM_PORTS(8), .ADDR_W(3), .TIMEOUT(5), .CNT_W(3)) dut_b (
    .clk(clk), .resetn(b_resetn), .detect_add(b_detect_add), .we_reg(b_we_reg),
    .datain(b_datain), .re(b_re), .empty(b_empty), .full(b_full),
    .we(b_we), .fifo_full(b_fifo_full), .v_out(b_v_out), .soft_rst(b_soft_rst),
    .addr_err(b_addr_err), .sel_addr(b_sel_addr)
  );

  always #5 clk = ~clk;

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset;
    resetn = 1'b0;
    b_resetn = 1'b0;
    for (int i = 0; i < 6; i++) begin
      detect_add = 1'($urandom);
      we_reg     = 1'b0;
      datain     = 2'($urandom);
      re         = 3'($urandom);
      empty      = 3'($urandom);
      full       = 3'($urandom);
      tick();
      n_cmp++;
      if (we !== 3'b000) begin
        n_fail++; $display("FAIL reset_we: got %b expected 000", we);
      end
      n_cmp++;
      if (soft_rst !== 3'b000) begin
        n_fail++; $display("FAIL reset_soft_rst: got %b expected 000", soft_rst);
      end
      n_cmp++;
      if (addr_err !== 1'b0) begin
        n_fail++; $display("FAIL reset_addr_err: got %b expected 0", addr_err);
      end
      n_cmp++;
      if (sel_addr !== 2'd0) begin
        n_fail++; $display("FAIL reset_sel_addr: got %0d expected 0", sel_addr);
      end
      n_cmp++;
      if (fifo_full !== full[0]) begin
        n_fail++; $display("FAIL reset_fifo_full: got %b expected %b", fifo_full, full[0]);
      end
    end
    detect_add = 1'b0;
    re         = 3'b000;
    full       = 3'b000;
    empty      = 3'b101;
    resetn     = 1'b1;
    #1;
    n_cmp++;
    if (v_out !== 3'b010) begin
      n_fail++; $display("FAIL reset_v_out: got %b expected 010", v_out);
    end
    empty = 3'b111;
    tick();
    b_resetn = 1'b1;
    tick();
  endtask

  task automatic test_steering;
    detect_add = 1'b1;
    datain     = 2'd2;
    tick();
    detect_add = 1'b0;
    n_cmp++;
    if (sel_addr !== 2'd2 || addr_err !== 1'b0) begin
      n_fail++; $display("FAIL steer_latch: got sel=%0d err=%b expected sel=2 err=0", sel_addr, addr_err);
    end
    we_reg = 1'b1;
    for (int k = 0; k < 4; k++) begin
      #1;
      n_cmp++;
      if (we !== 3'b100) begin
        n_fail++; $display("FAIL steer_we[%0d]: got %b expected 100", k, we);
      end
      tick();
    end
    we_reg = 1'b0;
    #1;
    n_cmp++;
    if (we !== 3'b000) begin
      n_fail++; $display("FAIL steer_we_idle: got %b expected 000", we);
    end
    full = 3'b100;
    #1;
    n_cmp++;
    if (fifo_full !== 1'b1) begin
      n_fail++; $display("FAIL steer_full_sel: got %b expected 1", fifo_full);
    end
    full = 3'b001;
    #1;
    n_cmp++;
    if (fifo_full !== 1'b0) begin
      n_fail++; $display("FAIL steer_full_other: got %b expected 0", fifo_full);
    end
    full = 3'b000;
    tick();
  endtask

  task automatic test_same_cycle;
    detect_add = 1'b1;
    datain     = 2'd1;
    tick();
    detect_add = 1'b1;
    datain     = 2'd0;
    we_reg     = 1'b1;
    #1;
    n_cmp++;
    if (we !== 3'b010) begin
      n_fail++; $display("FAIL same_cycle_old: got %b expected 010", we);
    end
    tick();
    detect_add = 1'b0;
    #1;
    n_cmp++;
    if (we !== 3'b001 || sel_addr !== 2'd0) begin
      n_fail++; $display("FAIL same_cycle_new: got we=%b sel=%0d expected we=001 sel=0", we, sel_addr);
    end
    we_reg = 1'b0;
    tick();
  endtask

  task automatic test_timeout;
    logic [2:0] exp;
    empty = 3'b110;
    re    = 3'b000;
    #1;
    n_cmp++;
    if (v_out !== 3'b001) begin
      n_fail++; $display("FAIL timeout_v_out: got %b expected 001", v_out);
    end
    for (int k = 1; k <= 60; k++) begin
      tick();
      exp = (k == 30 || k == 60) ? 3'b001 : 3'b000;
      n_cmp++;
      if (soft_rst !== exp) begin
        n_fail++; $display("FAIL timeout_pulse edge %0d: got %b expected %b", k, soft_rst, exp);
      end
    end
    empty = 3'b111;
    tick();
    empty = 3'b110;
    for (int k = 1; k <= 29; k++) begin
      tick();
    end
    re = 3'b001;
    tick();
    n_cmp++;
    if (soft_rst !== 3'b000) begin
      n_fail++; $display("FAIL timeout_read_last: got %b expected 000", soft_rst);
    end
    re = 3'b000;
    for (int k = 1; k <= 30; k++) begin
      tick();
      exp = (k == 30) ? 3'b001 : 3'b000;
      n_cmp++;
      if (soft_rst !== exp) begin
        n_fail++; $display("FAIL timeout_restart edge %0d: got %b expected %b", k, soft_rst, exp);
      end
    end
    empty = 3'b111;
    tick();
  endtask

  task automatic test_invalid_addr;
    detect_add = 1'b1;
    datain     = 2'd3;
    tick();
    detect_add = 1'b0;
    we_reg     = 1'b1;
    full       = 3'b111;
    #1;
    n_cmp++;
    if (addr_err !== 1'b1 || sel_addr !== 2'd3) begin
      n_fail++; $display("FAIL invalid_flag: got err=%b sel=%0d expected err=1 sel=3", addr_err, sel_addr);
    end
    n_cmp++;
    if (we !== 3'b000) begin
      n_fail++; $display("FAIL invalid_we: got %b expected 000", we);
    end
    n_cmp++;
    if (fifo_full !== 1'b0) begin
      n_fail++; $display("FAIL invalid_full: got %b expected 0", fifo_full);
    end
    we_reg     = 1'b0;
    detect_add = 1'b1;
    datain     = 2'd1;
    tick();
    detect_add = 1'b0;
    we_reg     = 1'b1;
    #1;
    n_cmp++;
    if (addr_err !== 1'b0 || fifo_full !== 1'b1 || we !== 3'b010) begin
      n_fail++; $display("FAIL invalid_recover: got err=%b full=%b we=%b expected err=0 full=1 we=010",
                         addr_err, fifo_full, we);
    end
    we_reg = 1'b0;
    full   = 3'b000;
    tick();
  endtask

  task automatic test_params;
    logic [7:0] exp;
    b_detect_add = 1'b1;
    b_datain     = 3'd6;
    tick();
    b_detect_add = 1'b0;
    b_we_reg     = 1'b1;
    #1;
    n_cmp++;
    if (b_we !== 8'h40 || b_addr_err !== 1'b0) begin
      n_fail++; $display("FAIL params_steer: got we=%h err=%b expected we=40 err=0", b_we, b_addr_err);
    end
    b_we_reg = 1'b0;
    b_empty  = 8'h5F;
    for (int k = 1; k <= 10; k++) begin
      tick();
      exp = (k == 5 || k == 10) ? 8'hA0 : 8'h00;
      n_cmp++;
      if (b_soft_rst !== exp) begin
        n_fail++; $display("FAIL params_pulse edge %0d: got %h expected %h", k, b_soft_rst, exp);
      end
    end
    b_empty = 8'hFF;
    tick();
    b_empty = 8'h5F;
    for (int k = 1; k <= 3; k++) begin
      tick();
    end
    b_resetn = 1'b0;
    #1;
    n_cmp++;
    if (b_soft_rst !== 8'h00) begin
      n_fail++; $display("FAIL params_in_reset: got %h expected 00", b_soft_rst);
    end
    tick();
    n_cmp++;
    if (b_soft_rst !== 8'h00) begin
      n_fail++; $display("FAIL params_held_reset: got %h expected 00", b_soft_rst);
    end
    b_resetn = 1'b1;
    for (int k = 1; k <= 5; k++) begin
      tick();
      exp = (k == 5) ? 8'hA0 : 8'h00;
      n_cmp++;
      if (b_soft_rst !== exp) begin
        n_fail++; $display("FAIL params_after_reset edge %0d: got %h expected %h", k, b_soft_rst, exp);
      end
    end
    b_empty = 8'hFF;
    tick();
  endtask

  initial begin
    n_cmp        = 0;
    n_fail       = 0;
    clk          = 1'b0;
    resetn       = 1'b0;
    detect_add   = 1'b0;
    we_reg       = 1'b0;
    datain       = 2'd0;
    re           = 3'b000;
    empty        = 3'b111;
    full         = 3'b000;
    b_resetn     = 1'b0;
    b_detect_add = 1'b0;
    b_we_reg     = 1'b0;
    b_datain     = 3'd0;
    b_re         = 8'h00;
    b_empty      = 8'hFF;
    b_full       = 8'h00;
    test_reset();
    test_steering();
    test_same_cycle();
    test_timeout();
    test_invalid_addr();
    test_params();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
